// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states
// and byte-lane count.
package mem_access_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE,
    ST_ERR
  } state_t;

  // Encoding 2'b10 is not a real size; it behaves as a word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte/halfword lane extraction with sign/zero extension, and lane
// merge of right-justified store data into a fetched word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Offset 0 is the most significant lane, so the shift counts down from 24.
  assign byte_shift = {~offset, 3'b000};
  assign half_shift = {~offset[1], 4'b0000};
  assign lane_byte  = 8'(word >> byte_shift);
  assign lane_half  = 16'(word >> half_shift);

  always_comb begin
    load_data = word;
    merged    = wdata;
    if (size == SIZE_BYTE) begin
      load_data = is_unsigned ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      merged    = (word & ~(32'h0000_00FF << byte_shift)) | ({24'b0, wdata[7:0]} << byte_shift);
    end else if (size == SIZE_HALF) begin
      load_data = is_unsigned ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
      merged    = (word & ~(32'h0000_FFFF << half_shift)) | ({16'b0, wdata[15:0]} << half_shift);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a big-endian word memory: loads, word stores and
// read-modify-write sub-word stores. Define MEM_ACCESS_ALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 12
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_store,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0] i_wdata,
  output logic [NB_DATA-1:0] o_rdata,
  output logic               o_done,
  output logic               o_err,
  output logic               o_mem_we,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_data,
  input  logic [NB_DATA-1:0] i_mem_data
);

  state_t       state;
  logic         store_q;
  logic [1:0]   size_q;
  logic         unsigned_q;
  logic [1:0]   offset_q;
  logic [31:0]  wdata_q;
  logic [31:0]  load_data;
  logic [31:0]  merged;
  logic         misaligned;
  logic         err_q;

`ifdef MEM_ACCESS_ALIGN_TRAP_EN
  assign misaligned = ((i_size == SIZE_HALF) && i_addr[0]) ||
                      (is_word(i_size) && (i_addr[1:0] != 2'b00));
  assign o_err      = err_q;
`else
  assign misaligned = 1'b0;
  assign o_err      = 1'b0;
`endif

  mem_lane_align u_lane_align (
    .word        (i_mem_data),
    .offset      (offset_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      o_ready    <= 1'b1;
      o_done     <= 1'b0;
      err_q      <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
      o_rdata    <= '0;
      store_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      offset_q   <= 2'b00;
      wdata_q    <= '0;
    end else begin
      o_done   <= 1'b0;
      err_q    <= 1'b0;
      o_mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            store_q    <= i_store;
            size_q     <= i_size;
            unsigned_q <= i_unsigned;
            offset_q   <= i_addr[1:0];
            wdata_q    <= i_wdata;
            o_mem_addr <= {i_addr[NB_ADDR-1:2], 2'b00};
            o_ready    <= 1'b0;
            if (misaligned) begin
              state  <= ST_ERR;
              o_done <= 1'b1;
              err_q  <= 1'b1;
            end else if (i_store && is_word(i_size)) begin
              state      <= ST_WR;
              o_mem_we   <= 1'b1;
              o_mem_data <= i_wdata;
            end else begin
              state <= ST_RD;
            end
          end
        end
        // The async read data is valid here; loads finish, sub-word stores merge.
        ST_RD: begin
          if (store_q) begin
            o_mem_data <= merged;
            o_mem_we   <= 1'b1;
            state      <= ST_WR;
          end else begin
            o_rdata <= load_data;
            o_done  <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_WR: begin
          o_done <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE, ST_ERR: begin
          o_ready <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          o_ready <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-array reference memory,
// directed cases followed by randomized loads/stores. Honours MEM_ACCESS_ALIGN_TRAP_EN.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_store;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [11:0] i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_done;
  logic        o_err;
  logic        o_mem_we;
  logic [11:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic [31:0] i_mem_data;

  logic [31:0] mem_words [1024];
  logic [7:0]  ref_mem [4096];
  logic        bd_we;
  logic [9:0]  bd_idx;
  logic [31:0] bd_data;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.NB_DATA(32), .NB_ADDR(12)) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_store    (i_store),
    .i_size     (i_size),
    .i_unsigned (i_unsigned),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .i_mem_data (i_mem_data)
  );

  // Word-wide memory the DUT talks to; the bench can also load it directly.
  assign i_mem_data = mem_words[o_mem_addr[11:2]];
  always @(posedge clk) begin
    if (bd_we) mem_words[bd_idx] <= bd_data;
    else if (o_mem_we) mem_words[o_mem_addr[11:2]] <= o_mem_data;
  end

  task automatic checkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a & 32'hFFC;
    return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input int a);
    logic [7:0]  b;
    logic [15:0] h;
    int base;
    if (sz == 2'b00) begin
      b = ref_mem[a];
      return uns ? {24'b0, b} : {{24{b[7]}}, b};
    end else if (sz == 2'b01) begin
      base = a & 32'hFFE;
      h = {ref_mem[base], ref_mem[base+1]};
      return uns ? {16'b0, h} : {{16{h[15]}}, h};
    end
    return ref_word(a);
  endfunction

  task automatic ref_store(input logic [1:0] sz, input int a, input logic [31:0] wd);
    int base;
    if (sz == 2'b00) begin
      ref_mem[a] = wd[7:0];
    end else if (sz == 2'b01) begin
      base = a & 32'hFFE;
      ref_mem[base]   = wd[15:8];
      ref_mem[base+1] = wd[7:0];
    end else begin
      base = a & 32'hFFC;
      ref_mem[base]   = wd[31:24];
      ref_mem[base+1] = wd[23:16];
      ref_mem[base+2] = wd[15:8];
      ref_mem[base+3] = wd[7:0];
    end
  endtask

  task automatic preload(input int a, input logic [31:0] w);
    int b;
    b = a & 32'hFFC;
    bd_we   = 1'b1;
    bd_idx  = 10'(b >> 2);
    bd_data = w;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[b] = w[31:24]; ref_mem[b+1] = w[23:16];
    ref_mem[b+2] = w[15:8]; ref_mem[b+3] = w[7:0];
  endtask

  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic uns,
                               input logic [11:0] a, input logic [31:0] wd);
    int cycles, writes, wr_cycle, exp_lat;
    logic exp_err, done;
    logic [31:0] exp_rdata, wr_data;
    logic [11:0] wr_addr;
    exp_err = 1'b0;
`ifdef MEM_ACCESS_ALIGN_TRAP_EN
    exp_err = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`endif
    exp_lat   = exp_err ? 1 : (!st ? 2 : (sz[1] ? 2 : 3));
    exp_rdata = ref_load(sz, uns, int'(a));
    if (st && !exp_err) ref_store(sz, int'(a), wd);

    cycles = 0;
    while (!o_ready && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    checkv("ready_before_req", 32'(o_ready), 32'd1);

    i_valid = 1'b1; i_store = st; i_size = sz; i_unsigned = uns; i_addr = a; i_wdata = wd;
    @(posedge clk);
    #1 i_valid = 1'b0;
    i_wdata = $urandom;

    cycles = 0; writes = 0; wr_cycle = 0; done = 1'b0;
    wr_addr = '0; wr_data = '0;
    while (!done && cycles < 10) begin
      @(negedge clk);
      cycles++;
      if (o_mem_we) begin
        writes++;
        wr_cycle = cycles;
        wr_addr = o_mem_addr;
        wr_data = o_mem_data;
      end
      if (o_done) done = 1'b1;
    end
    checkv("done_latency", 32'(cycles), 32'(exp_lat));
    checkv("err_flag", 32'(o_err), 32'(exp_err));
    checkv("ready_low_at_done", 32'(o_ready), 32'd0);
    checkv("write_count", 32'(writes), (st && !exp_err) ? 32'd1 : 32'd0);
    if (!st && !exp_err) checkv("load_data", o_rdata, exp_rdata);
    if (st && !exp_err) begin
      checkv("write_cycle", 32'(wr_cycle), 32'(exp_lat - 1));
      checkv("write_addr", 32'(wr_addr), 32'(a & 12'hFFC));
      checkv("write_data", wr_data, ref_word(int'(a)));
    end
    @(negedge clk);
    checkv("mem_word", mem_words[a[11:2]], ref_word(int'(a)));
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] exp);
    checkv(tag, o_rdata, exp);
  endtask

  initial begin
    int writes;
    logic [11:0] ra;
    logic [1:0]  rs;
    i_rst = 1'b1; i_valid = 1'b0; i_store = 1'b0; i_size = 2'b00;
    i_unsigned = 1'b0; i_addr = '0; i_wdata = '0;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    repeat (2) @(negedge clk);
    checkv("rst_ready", 32'(o_ready), 32'd1);
    checkv("rst_done", 32'(o_done), 32'd0);
    checkv("rst_we", 32'(o_mem_we), 32'd0);
    checkv("rst_addr", 32'(o_mem_addr), 32'd0);
    checkv("rst_err", 32'(o_err), 32'd0);
    checkv("rst_rdata", o_rdata, 32'd0);

    for (int i = 0; i < 1024; i++) preload(i * 4, $urandom);
    i_rst = 1'b0;
    @(negedge clk);
    $display("[TB] memory initialised, starting directed steps");

    applyStimulus(1'b1, 2'b11, 1'b0, 12'h010, 32'hDEADBEEF);
    checkv("sw_word", mem_words[4], 32'hDEADBEEF);

    preload(12'h010, 32'h11223344);
    applyStimulus(1'b1, 2'b00, 1'b0, 12'h012, 32'h000000AA);
    checkv("sb_word", mem_words[4], 32'h1122AA44);
    applyStimulus(1'b1, 2'b01, 1'b0, 12'h010, 32'h0000BEEF);
    checkv("sh_word", mem_words[4], 32'hBEEFAA44);

    preload(12'h010, 32'h11F28344);
    applyStimulus(1'b0, 2'b00, 1'b0, 12'h011, 32'h0);
    checkOutput("lb_const", 32'hFFFFFFF2);
    applyStimulus(1'b0, 2'b00, 1'b1, 12'h011, 32'h0);
    checkOutput("lbu_const", 32'h000000F2);
    applyStimulus(1'b0, 2'b01, 1'b0, 12'h012, 32'h0);
    checkOutput("lh_const", 32'hFFFF8344);
    applyStimulus(1'b0, 2'b01, 1'b1, 12'h012, 32'h0);
    checkOutput("lhu_const", 32'h00008344);
    applyStimulus(1'b0, 2'b11, 1'b0, 12'h010, 32'h0);
    checkOutput("lw_const", 32'h11F28344);

    applyStimulus(1'b0, 2'b11, 1'b0, 12'h013, 32'h0);
`ifndef MEM_ACCESS_ALIGN_TRAP_EN
    checkOutput("lw_unaligned_base", 32'h11F28344);
`endif
    applyStimulus(1'b1, 2'b11, 1'b0, 12'hFFF, 32'hCAFEF00D);
    applyStimulus(1'b1, 2'b00, 1'b0, 12'hFFF, 32'h0000005A);
    applyStimulus(1'b0, 2'b10, 1'b0, 12'hFFC, 32'h0);

    // Reset landing on the read cycle of a sub-word store must suppress the write.
    preload(12'h010, 32'h11223344);
    i_valid = 1'b1; i_store = 1'b1; i_size = 2'b00; i_unsigned = 1'b0;
    i_addr = 12'h012; i_wdata = 32'h000000AA;
    @(posedge clk);
    #1 i_valid = 1'b0;
    @(negedge clk);
    checkv("rst_mid_rd_we", 32'(o_mem_we), 32'd0);
    i_rst = 1'b1;
    @(negedge clk);
    checkv("rst_mid_ready", 32'(o_ready), 32'd1);
    checkv("rst_mid_done", 32'(o_done), 32'd0);
    i_rst = 1'b0;
    writes = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_mem_we) writes++;
    end
    checkv("rst_mid_no_write", 32'(writes), 32'd0);
    checkv("rst_mid_mem", mem_words[4], 32'h11223344);
    checkv("rst_mid_idle", 32'(o_ready), 32'd1);

    for (int n = 0; n < 300; n++) begin
      ra = ($urandom_range(0, 9) == 0) ? 12'(4095 - $urandom_range(0, 3))
                                       : 12'($urandom_range(0, 255));
      rs = 2'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
